// File: rtl/iir_pkg.sv
// Shared widths and types for the iir_biquad filter kernel.
// The saturating output stage is selected with the IIR_SAT_EN macro (see iir_sat).
package iir_pkg;

  localparam int DIN_W   = 8;
  localparam int DOUT_W  = 17;
  localparam int BCOEF_W = 6;
  localparam int ACOEF_W = 8;
  localparam int ACC_W   = 27;
  localparam int FF_W    = 16;

  typedef logic        [DIN_W-1:0]  sample_t;
  typedef logic        [DOUT_W-1:0] out_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Largest value representable on the unsigned output.
  localparam acc_t OUT_MAX = acc_t'((1 << DOUT_W) - 1);

endpackage

// File: rtl/iir_sat.sv
// Narrows the signed 27-bit accumulator to the unsigned 17-bit output.
// IIR_SAT_EN defined: clamp to [0, 131071]; undefined: keep the low 17 bits (wrap).
module iir_sat
  import iir_pkg::*;
(
  input  acc_t sum_i,
  output out_t sat_o
);

`ifdef IIR_SAT_EN
  always_comb begin
    sat_o = sum_i[DOUT_W-1:0];
    if (sum_i < 0) begin
      sat_o = '0;
    end else if (sum_i > OUT_MAX) begin
      sat_o = '1;
    end
  end
`else
  // Upper accumulator bits are intentionally dropped in the wrapping build.
  logic unused_hi;
  assign unused_hi = ^sum_i[ACC_W-1:DOUT_W];

  always_comb begin
    sat_o = sum_i[DOUT_W-1:0];
  end
`endif

endmodule

// File: rtl/iir_biquad.sv
// Direct-form-I second-order IIR on an unsigned 8-bit stream, one sample per clock.
// Output narrowing is clamping when IIR_SAT_EN is defined, wrapping otherwise.
module iir_biquad
  import iir_pkg::*;
#(
  parameter logic        [BCOEF_W-1:0] B0       = 6'd1,
  parameter logic        [BCOEF_W-1:0] B1       = 6'd2,
  parameter logic        [BCOEF_W-1:0] B2       = 6'd1,
  parameter logic signed [ACOEF_W-1:0] A1       = 8'sd8,
  parameter logic signed [ACOEF_W-1:0] A2       = -8'sd2,
  parameter int                        FB_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIN_W-1:0]  datain,
  output logic [DOUT_W-1:0] dataout
);

  // Coefficients sign-extended once so the MACs run entirely at accumulator width.
  localparam acc_t A1_EXT = acc_t'(A1);
  localparam acc_t A2_EXT = acc_t'(A2);

  sample_t           samples_q [3];
  sample_t           samples_d [3];
  out_t              y1_q, y1_d;
  out_t              y2_q, y2_d;

  logic [FF_W-1:0]   ff_mul [3];
  logic [FF_W-1:0]   data_feedforward;
  acc_t              y1_ext, y2_ext;
  acc_t              fb_raw;
  acc_t              data_feedback;
  acc_t              sum;
  out_t              sum_sat;

  always_comb begin
    ff_mul[0]        = FF_W'(B0) * FF_W'(samples_q[0]);
    ff_mul[1]        = FF_W'(B1) * FF_W'(samples_q[1]);
    ff_mul[2]        = FF_W'(B2) * FF_W'(samples_q[2]);
    data_feedforward = ff_mul[0] + ff_mul[1] + ff_mul[2];

    y1_ext        = acc_t'(y1_q);
    y2_ext        = acc_t'(y2_q);
    fb_raw        = A1_EXT * y1_ext + A2_EXT * y2_ext;
    // Arithmetic shift floors toward minus infinity for negative feedback.
    data_feedback = fb_raw >>> FB_SHIFT;

    sum = acc_t'(data_feedforward) + data_feedback;
  end

  iir_sat u_sat (
    .sum_i (sum),
    .sat_o (sum_sat)
  );

  always_comb begin
    samples_d[0] = datain;
    samples_d[1] = samples_q[0];
    samples_d[2] = samples_q[1];
    y1_d         = sum_sat;
    y2_d         = y1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        samples_q[i] <= '0;
      end
      y1_q <= '0;
      y2_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        samples_q[i] <= samples_d[i];
      end
      y1_q <= y1_d;
      y2_q <= y2_d;
    end
  end

  // The y[n-1] history register doubles as the registered output.
  assign dataout = y1_q;

endmodule

// File: tb/tb_iir_biquad.sv
// Self-checking bench for iir_biquad: three instances (default, growing feedback,
// strong negative feedback) compared every cycle against a difference-equation model.
module tb_iir_biquad;

  logic        clk    = 1'b0;
  logic        rst    = 1'b0;
  logic [7:0]  datain = 8'd0;
  logic [16:0] dout [3];

  // Per-instance coefficients: 0 = defaults, 1 = A1=16/A2=0, 2 = A1=0/A2=-128/shift 0.
  localparam longint P_B  [3] = '{1, 2, 1};
  localparam longint P_A1 [3] = '{8, 16, 0};
  localparam longint P_A2 [3] = '{-2, 0, -128};
  localparam longint P_SH [3] = '{4, 4, 0};

  int          n_checks = 0;
  int          n_pass   = 0;

  longint      xh [3][$];
  longint      yh [3][$];
  longint      exp_y [3];
  logic [16:0] exp_q [$];
  longint      step_resp [12];

  iir_biquad u_def (
    .clk     (clk),
    .rst     (rst),
    .datain  (datain),
    .dataout (dout[0])
  );

  iir_biquad #(
    .A1 (8'sd16),
    .A2 (8'sd0)
  ) u_grow (
    .clk     (clk),
    .rst     (rst),
    .datain  (datain),
    .dataout (dout[1])
  );

  iir_biquad #(
    .A1       (8'sd0),
    .A2       (8'sh80),
    .FB_SHIFT (0)
  ) u_neg (
    .clk     (clk),
    .rst     (rst),
    .datain  (datain),
    .dataout (dout[2])
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic longint floor_div(input longint v, input longint d);
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic longint sat_model(input longint v);
`ifdef IIR_SAT_EN
    if (v < 0) return 0;
    if (v > 131071) return 131071;
    return v;
`else
    return v & 64'h1FFFF;
`endif
  endfunction

  // y[n] = sat(B0 x[n] + B1 x[n-1] + B2 x[n-2] + floor((A1 y[n-1] + A2 y[n-2]) / 2^sh)),
  // where x[n] is the newest sample already captured before this edge.
  function automatic void model_edge(input int i, input logic [7:0] d, input logic r);
    longint ff, fbs;
    int     nx, ny;
    if (!r) begin
      xh[i].delete();
      yh[i].delete();
      exp_y[i] = 0;
    end else begin
      ff  = 0;
      fbs = 0;
      nx  = xh[i].size();
      ny  = yh[i].size();
      for (int k = 0; k < 3; k++) begin
        if (k < nx) ff += P_B[k] * xh[i][nx-1-k];
      end
      if (ny >= 1) fbs += P_A1[i] * yh[i][ny-1];
      if (ny >= 2) fbs += P_A2[i] * yh[i][ny-2];
      exp_y[i] = sat_model(ff + floor_div(fbs, longint'(1) << P_SH[i]));
      yh[i].push_back(exp_y[i]);
      xh[i].push_back(longint'(d));
      if (xh[i].size() > 3) void'(xh[i].pop_front());
      if (yh[i].size() > 3) void'(yh[i].pop_front());
    end
  endfunction

  // ---------------- driver ----------------
  task automatic tick(input logic [7:0] d, input logic r);
    datain = d;
    rst    = r;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) model_edge(i, d, r);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick(8'd200, 1'b0);
    tick(8'd200, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dout[i] !== 17'd0) $display("FAIL reset_out[%0d]: got %0d want 0", i, dout[i]);
      else n_pass++;
    end
    // History was cleared, so the first released edge still shows zero.
    tick(8'd200, 1'b1);
    n_checks++;
    if (dout[0] !== 17'd0) $display("FAIL reset_first_release: got %0d want 0", dout[0]);
    else n_pass++;
    tick(8'd200, 1'b1);
    n_checks++;
    if (dout[0] !== 17'd200) $display("FAIL reset_second_release: got %0d want 200", dout[0]);
    else n_pass++;
  endtask

  task automatic test_impulse();
    logic [16:0] e;
    tick(8'd0, 1'b0);
    tick(8'd16, 1'b1);
    n_checks++;
    if (dout[0] !== 17'd0) $display("FAIL impulse_latency: got %0d want 0", dout[0]);
    else n_pass++;
    exp_q = '{17'd16, 17'd40, 17'd34, 17'd12};
    while (exp_q.size() > 0) begin
      tick(8'd0, 1'b1);
      e = exp_q.pop_front();
      n_checks++;
      if (dout[0] !== e) $display("FAIL impulse_seq: got %0d want %0d", dout[0], e);
      else n_pass++;
    end
    for (int n = 0; n < 8; n++) begin
      tick(8'd0, 1'b1);
      n_checks++;
      if (dout[0] !== exp_y[0]) $display("FAIL impulse_decay[%0d]: got %0d want %0d", n, dout[0], exp_y[0]);
      else n_pass++;
    end
  endtask

  task automatic test_dc_step();
    logic [16:0] prev;
    tick(8'd0, 1'b0);
    prev = '0;
    for (int n = 0; n < 40; n++) begin
      tick(8'd255, 1'b1);
      if (n < 12) step_resp[n] = exp_y[0];
      n_checks++;
      if (dout[0] !== exp_y[0]) $display("FAIL step_model[%0d]: got %0d want %0d", n, dout[0], exp_y[0]);
      else n_pass++;
      if (n >= 30) begin
        n_checks++;
        if (dout[0] !== prev) $display("FAIL step_steady[%0d]: got %0d want %0d", n, dout[0], prev);
        else n_pass++;
      end
      prev = dout[0];
    end
    // Real-valued fixed point is 1632; floor rounding may settle one LSB below.
    n_checks++;
    if ((dout[0] > 17'd1633) || (dout[0] < 17'd1631))
      $display("FAIL step_final: got %0d want 1632 +/- 1", dout[0]);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    tick(8'd255, 1'b1);
    tick(8'd255, 1'b1);
    tick(8'd255, 1'b0);
    n_checks++;
    if (dout[0] !== 17'd0) $display("FAIL midreset_zero: got %0d want 0", dout[0]);
    else n_pass++;
    for (int n = 0; n < 12; n++) begin
      tick(8'd255, 1'b1);
      n_checks++;
      if (dout[0] !== step_resp[n]) $display("FAIL midreset_fresh[%0d]: got %0d want %0d", n, dout[0], step_resp[n]);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    logic [16:0] prev;
    logic        wrapped;
    tick(8'd0, 1'b0);
    prev    = '0;
    wrapped = 1'b0;
    for (int n = 0; n < 160; n++) begin
      tick(8'd255, 1'b1);
      n_checks++;
      if (dout[1] !== exp_y[1]) $display("FAIL sat_model[%0d]: got %0d want %0d", n, dout[1], exp_y[1]);
      else n_pass++;
`ifdef IIR_SAT_EN
      n_checks++;
      if (dout[1] < prev) $display("FAIL sat_monotonic[%0d]: got %0d want >= %0d", n, dout[1], prev);
      else n_pass++;
`endif
      if (dout[1] < prev) wrapped = 1'b1;
      prev = dout[1];
    end
`ifdef IIR_SAT_EN
    n_checks++;
    if (dout[1] !== 17'd131071) $display("FAIL sat_stick: got %0d want 131071", dout[1]);
    else n_pass++;
`else
    n_checks++;
    if (wrapped !== 1'b1) $display("FAIL wrap_seen: got %0d want 1", wrapped);
    else n_pass++;
`endif
  endtask

  task automatic test_neg_clamp();
    logic [16:0] got [7];
    tick(8'd0, 1'b0);
    for (int n = 0; n < 7; n++) begin
      tick((n == 0) ? 8'd255 : 8'd0, 1'b1);
      got[n] = dout[2];
      n_checks++;
      if (dout[2] !== exp_y[2]) $display("FAIL neg_model[%0d]: got %0d want %0d", n, dout[2], exp_y[2]);
      else n_pass++;
    end
    n_checks++;
    if (got[1] !== 17'd255) $display("FAIL neg_first: got %0d want 255", got[1]);
    else n_pass++;
    n_checks++;
    if (got[2] !== 17'd510) $display("FAIL neg_second: got %0d want 510", got[2]);
    else n_pass++;
`ifdef IIR_SAT_EN
    n_checks++;
    if ((got[3] !== 17'd0) || (got[4] !== 17'd0))
      $display("FAIL neg_clamp: got %0d,%0d want 0,0", got[3], got[4]);
    else n_pass++;
`else
    n_checks++;
    if (got[3] !== 17'd98687) $display("FAIL neg_wrap: got %0d want 98687", got[3]);
    else n_pass++;
`endif
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       r;
    for (int n = 0; n < 400; n++) begin
      d = 8'($urandom_range(0, 255));
      r = ($urandom_range(0, 49) != 0);
      tick(d, r);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (dout[i] !== exp_y[i]) $display("FAIL random[%0d][%0d]: got %0d want %0d", n, i, dout[i], exp_y[i]);
        else n_pass++;
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_impulse();
    test_dc_step();
    test_mid_reset();
    test_saturation();
    test_neg_clamp();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
